fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of decode. Generates the fetch PC and issues in-order requests to the instruction memory over a valid/ready request port with a variable-latency response. Buffers returned words in a small in-order queue and drives the fetch/decode pipeline register (pcD, instrD, validD). Handles hazard-unit stalls, flushes, and branch/jump redirects from execute.

Parameters:
RESET_PC, 32'h0000_1000, first fetch address after reset
QDEPTH, 2, fetch-queue entries; also the cap on in-flight requests (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
en  in  1  decode-register enable from hazard unit; 0 = stall
flush  in  1  kill the decode-register contents (bubble)
pcSrcE  in  1  redirect request from execute
pcTargetE  in  WORD  redirect target
imemReq  out  1  request valid
imemAddr  out  WORD  request address (word aligned)
imemReady  in  1  memory accepts request this cycle
imemRvalid  in  1  response valid; responses strictly in request order
imemRdata  in  WORD  response instruction
pcD  out  WORD  PC of instruction in decode
instrD  out  WORD  instruction in decode
validD  out  1  decode slot holds a real instruction

Behaviour:
- Reset (async): fetchPC=RESET_PC; queue empty; drop counter 0; pcD=0, instrD=NOP (32'h0000_0013), validD=0; imemReq=0 while reset is high.
- Queue entry = {pc, instr, filled}. An entry is allocated at the tail on request accept (imemReq&&imemReady) with pc=imemAddr, filled=0. A response fills the oldest unfilled entry.
- imemReq = !pcSrcE && (entries + dropCnt) < QDEPTH. imemAddr = fetchPC. On accept, fetchPC += 4 (wraps mod 2^WORD). imemAddr stays stable while imemReq=1 and imemReady=0.
- Redirect (pcSrcE=1): fetchPC <= pcTargetE; all queue entries are discarded. dropCnt <= (number of unfilled entries) - (imemRvalid ? 1 : 0), because a response arriving in the redirect cycle belongs to the oldest unfilled entry and is discarded. No request is issued in the redirect cycle. The next cycle requests pcTargetE.
- While dropCnt>0, each imemRvalid decrements dropCnt and its data is discarded.
- Decode register priority, highest first:
  1. flush || pcSrcE -> bubble (validD=0, pcD=0, instrD=NOP); applies even when en=0.
  2. en=0 -> hold all three outputs; no pop.
  3. head entry filled -> load pc/instr, validD=1, pop head.
  4. otherwise -> bubble.
- No response bypass: a word filled at edge N pops at the earliest at edge N+1. With a single-cycle memory, the instruction for a request accepted in cycle t is visible on instrD in cycle t+2.
- Simultaneous fill, pop and allocate in one cycle is legal. Count update = +alloc -pop.
- If imemRvalid arrives with no unfilled entry and dropCnt=0, it is ignored. This is a protocol error and is flagged by an assertion.
- Sustained throughput is 1 instruction/cycle with a 1-cycle memory and QDEPTH>=2.
- Reset mid-operation: all state is cleared regardless of in-flight requests. The memory side is reset by the same signal.

Decomposition:
- Shared package holds: WORD, INSTR_NOP (32'h0000_0013), RESET_PC default, and the queue-entry struct {pc, instr, filled}.
- Sub-module fetch_queue: circular buffer with head/tail/fill pointers and count. Ports: alloc/alloc_pc, fill/fill_data, pop, clear. Outputs: head entry, count, unfilled count.
- fetch_stage owns fetchPC, dropCnt, the request logic and the decode register.

Test Plan:
- Reset, imemReady=1, 1-cycle memory returning instr=addr^32'hA5A5_0000 -> pcD runs 0x1000, 0x1004, 0x1008… with validD=1 every cycle from cycle 2 after reset release.
- en=0 for 3 cycles mid-stream -> pcD/instrD/validD frozen. imemReq drops once entries=2. Afterwards pcD resumes at the next address with no skip or duplicate.
- Two requests in flight (3-cycle memory), pcSrcE=1 with pcTargetE=0x2000 -> both stale responses dropped (dropCnt 2->0). validD=0 until pcD=0x2000 appears, then 0x2004.
- imemRvalid asserted in the same cycle as pcSrcE with 2 in flight -> dropCnt=1. Exactly one later response is discarded, and the first valid pcD is the target.
- imemReady=0 for 5 cycles -> imemReq held at 1, imemAddr stable, validD=0 bubbles once the queue drains. No address is skipped when ready returns.
- Async reset pulse between clock edges mid-stream -> validD=0 and pcD=0 immediately, without waiting for a clock edge. Fetch restarts at 0x1000. A flush with en=0 still produces validD=0 on the next edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int WORD = 32;

    localparam logic [WORD-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [WORD-1:0] RESET_PC_DEFAULT = 32'h0000_1000;

    // One fetch-queue slot: request address, returned word, word-present flag.
    typedef struct packed {
        logic [WORD-1:0] pc;
        logic [WORD-1:0] instr;
        logic            filled;
    } qentry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated on request accept, filled in
// request order by memory responses, and popped from the head by decode.
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int QDEPTH = 2,
    localparam int PW = $clog2(QDEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc,
    input  logic [WORD-1:0] alloc_pc,
    input  logic            fill,
    input  logic [WORD-1:0] fill_data,
    input  logic            pop,
    input  logic            clear,
    output qentry_t         head,
    output logic [CW-1:0]   count,
    output logic [CW-1:0]   unfilled
);

    qentry_t         entries [QDEPTH];
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;
    logic [PW-1:0]   fill_ptr;
    logic            fill_ok;
    logic            pop_ok;

    assign fill_ok = fill && (unfilled != '0);
    assign pop_ok  = pop && (count != '0);

    // Pointer, counter and slot updates; clear drops every entry at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            count    <= '0;
            unfilled <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            count    <= '0;
            unfilled <= '0;
        end else begin
            if (alloc) begin
                entries[tail_ptr] <= '{pc: alloc_pc, instr: INSTR_NOP, filled: 1'b0};
                tail_ptr          <= tail_ptr + 1'b1;
            end
            if (fill_ok) begin
                entries[fill_ptr].instr  <= fill_data;
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + 1'b1;
            end
            if (pop_ok) begin
                head_ptr <= head_ptr + 1'b1;
            end
            count    <= count + CW'(alloc) - CW'(pop_ok);
            unfilled <= unfilled + CW'(alloc) - CW'(fill_ok);
        end
    end

    // Head view; a stale slot behind an empty queue never reports filled.
    always_comb begin
        head        = entries[head_ptr];
        head.filled = entries[head_ptr].filled && (count != '0);
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, in-order memory requests with
// variable-latency responses, stale-response dropping after redirects, and
// the fetch/decode pipeline register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            flush,
    input  logic            pcSrcE,
    input  logic [WORD-1:0] pcTargetE,
    output logic            imemReq,
    output logic [WORD-1:0] imemAddr,
    input  logic            imemReady,
    input  logic            imemRvalid,
    input  logic [WORD-1:0] imemRdata,
    output logic [WORD-1:0] pcD,
    output logic [WORD-1:0] instrD,
    output logic            validD
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [WORD-1:0] fetchPC;
    logic [CW-1:0]   dropCnt;
    logic [CW-1:0]   qCount;
    logic [CW-1:0]   qUnfilled;
    qentry_t         head;
    logic            bubble;
    logic            pop;
    logic            accept;
    logic            fill;
    logic [CW:0]     occupied;
    logic [CW:0]     pending;

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .alloc     (accept),
        .alloc_pc  (fetchPC),
        .fill      (fill),
        .fill_data (imemRdata),
        .pop       (pop),
        .clear     (pcSrcE),
        .head      (head),
        .count     (qCount),
        .unfilled  (qUnfilled)
    );

    // Request and handshake decisions for the current cycle.
    // A head popped this cycle frees its slot at the same edge, so it is not
    // counted as occupied; that is what lets two entries sustain 1 fetch/cycle.
    always_comb begin
        bubble   = flush || pcSrcE;
        pop      = !bubble && en && head.filled;
        occupied = (CW+1)'(qCount) + (CW+1)'(dropCnt) - (CW+1)'(pop);
        imemReq  = !reset && !pcSrcE && (occupied < (CW+1)'(QDEPTH));
        imemAddr = fetchPC;
        accept   = imemReq && imemReady;
        fill     = imemRvalid && (dropCnt == '0) && !pcSrcE;
        // Responses still owed on a redirect: earlier drops plus the queue's
        // unfilled entries, less the one arriving right now.
        pending  = (CW+1)'(dropCnt) + (CW+1)'(qUnfilled);
        if (imemRvalid && (pending != '0)) begin
            pending = pending - 1'b1;
        end
    end

    // Fetch PC advance/redirect and stale-response drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPC <= RESET_PC;
            dropCnt <= '0;
        end else if (pcSrcE) begin
            fetchPC <= pcTargetE;
            dropCnt <= CW'(pending);
        end else begin
            if (accept) begin
                fetchPC <= fetchPC + 32'd4;
            end
            if (imemRvalid && (dropCnt != '0)) begin
                dropCnt <= dropCnt - 1'b1;
            end
        end
    end

    // Fetch/decode register: kill, then stall, then load head, else bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcD    <= '0;
            instrD <= INSTR_NOP;
            validD <= 1'b0;
        end else if (bubble) begin
            pcD    <= '0;
            instrD <= INSTR_NOP;
            validD <= 1'b0;
        end else if (en) begin
            if (head.filled) begin
                pcD    <= head.pc;
                instrD <= head.instr;
                validD <= 1'b1;
            end else begin
                pcD    <= '0;
                instrD <= INSTR_NOP;
                validD <= 1'b0;
            end
        end
    end

    // A response with nothing outstanding means the memory broke the protocol.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imemRvalid && (dropCnt == '0) && (qUnfilled == '0)))
                else $error("fetch_stage: response with no outstanding request");
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small in-order memory responder.
// Memory words are addr ^ 32'hA5A5_0000; latency is selectable per request.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        flush = 1'b0;
    logic        pcSrcE = 1'b0;
    logic [31:0] pcTargetE = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b1;
    logic        imemRvalid = 1'b0;
    logic [31:0] imemRdata = '0;
    logic [31:0] pcD;
    logic [31:0] instrD;
    logic        validD;

    int checks = 0;
    int failures = 0;
    int memLat = 1;
    int edgeN = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];

    fetch_stage #(.RESET_PC(32'h0000_1000), .QDEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .flush      (flush),
        .pcSrcE     (pcSrcE),
        .pcTargetE  (pcTargetE),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemReady  (imemReady),
        .imemRvalid (imemRvalid),
        .imemRdata  (imemRdata),
        .pcD        (pcD),
        .instrD     (instrD),
        .validD     (validD)
    );

    always #5 clk = ~clk;

    // Memory responder: a request accepted at edge n is presented just after
    // edge n+memLat-1 and consumed by the following edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            imemRvalid = 1'b0;
            imemRdata  = '0;
        end else begin
            edgeN++;
            if (imemRvalid) begin
                void'(mq.pop_front());
            end
            if (imemReq && imemReady) begin
                mq.push_back('{imemAddr, edgeN + memLat - 1});
            end
            #1;
            if (mq.size() > 0 && mq[0].due <= edgeN) begin
                imemRvalid = 1'b1;
                imemRdata  = mq[0].addr ^ KEY;
            end else begin
                imemRvalid = 1'b0;
                imemRdata  = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_valid_instr(input string tag, input logic [31:0] pc);
        check({tag, "_validD"}, {31'd0, validD}, 32'd1);
        check({tag, "_pcD"}, pcD, pc);
        check({tag, "_instrD"}, instrD, pc ^ KEY);
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_validD"}, {31'd0, validD}, 32'd0);
    endtask

    initial begin
        // Reset state.
        @(negedge clk);
        check("rst_validD", {31'd0, validD}, 32'd0);
        check("rst_pcD", pcD, 32'd0);
        check("rst_instrD", instrD, NOP);
        check("rst_req", {31'd0, imemReq}, 32'd0);

        // Release; first request is RESET_PC, accepted at the next edge.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("start_req", {31'd0, imemReq}, 32'd1);
        check("start_addr", imemAddr, 32'h0000_1000);
        @(negedge clk);
        check_bubble("lat0");
        check("lat0_addr", imemAddr, 32'h0000_1004);
        @(negedge clk);
        check_bubble("lat1");

        // Streaming at one instruction per cycle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_valid_instr("stream", 32'h0000_1000 + 32'(4 * i));
        end

        // Three-cycle stall: decode frozen, requests stop with two entries.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_valid_instr("stall", 32'h0000_100C);
            check("stall_req", {31'd0, imemReq}, 32'd0);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_valid_instr("resume", 32'h0000_1010 + 32'(4 * i));
        end

        // Switch to 3-cycle memory; two requests end up in flight.
        memLat = 3;
        @(negedge clk);
        check_valid_instr("lat3a", 32'h0000_101C);
        @(negedge clk);
        check_valid_instr("lat3b", 32'h0000_1020);

        // Redirect with two unfilled entries and no response this cycle.
        pcSrcE    = 1'b1;
        pcTargetE = 32'h0000_2000;
        #1;
        check("redir_req", {31'd0, imemReq}, 32'd0);
        @(negedge clk);
        pcSrcE = 1'b0;
        #1;
        check_bubble("redir0");
        check("drop2_req", {31'd0, imemReq}, 32'd0);
        @(negedge clk);
        check_bubble("redir1");
        check("drop1_req", {31'd0, imemReq}, 32'd1);
        check("drop1_addr", imemAddr, 32'h0000_2000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_bubble("redir_wait");
        end
        @(negedge clk);
        check_valid_instr("tgt0", 32'h0000_2000);
        @(negedge clk);
        check_valid_instr("tgt1", 32'h0000_2004);

        // Redirect in the same cycle as a response: only one more is dropped.
        @(negedge clk);
        check_bubble("pre_redir2");
        pcSrcE    = 1'b1;
        pcTargetE = 32'h0000_3000;
        @(negedge clk);
        pcSrcE = 1'b0;
        #1;
        check_bubble("redir2_0");
        check("redir2_req", {31'd0, imemReq}, 32'd1);
        check("redir2_addr", imemAddr, 32'h0000_3000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_bubble("redir2_wait");
        end
        @(negedge clk);
        check_valid_instr("tgt2_0", 32'h0000_3000);
        @(negedge clk);
        check_valid_instr("tgt2_1", 32'h0000_3004);

        // imemReady low for five cycles; back to 1-cycle memory.
        memLat    = 1;
        imemReady = 1'b0;
        @(negedge clk);
        check_bubble("nrdy0");
        check("nrdy0_req", {31'd0, imemReq}, 32'd0);
        @(negedge clk);
        check_bubble("nrdy1");
        check("nrdy1_req", {31'd0, imemReq}, 32'd1);
        check("nrdy1_addr", imemAddr, 32'h0000_3010);
        @(negedge clk);
        check_valid_instr("nrdy2", 32'h0000_3008);
        check("nrdy2_req", {31'd0, imemReq}, 32'd1);
        check("nrdy2_addr", imemAddr, 32'h0000_3010);
        @(negedge clk);
        check_valid_instr("nrdy3", 32'h0000_300C);
        check("nrdy3_addr", imemAddr, 32'h0000_3010);
        @(negedge clk);
        check_bubble("nrdy4");
        check("nrdy4_req", {31'd0, imemReq}, 32'd1);
        check("nrdy4_addr", imemAddr, 32'h0000_3010);
        imemReady = 1'b1;
        @(negedge clk);
        check_bubble("rdy0");
        check("rdy0_addr", imemAddr, 32'h0000_3014);
        @(negedge clk);
        check_bubble("rdy1");
        @(negedge clk);
        check_valid_instr("rdy2", 32'h0000_3010);
        @(negedge clk);
        check_valid_instr("rdy3", 32'h0000_3014);

        // Asynchronous reset pulse between clock edges.
        #2;
        reset = 1'b1;
        #1;
        check("arst_validD", {31'd0, validD}, 32'd0);
        check("arst_pcD", pcD, 32'd0);
        check("arst_instrD", instrD, NOP);
        check("arst_req", {31'd0, imemReq}, 32'd0);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_bubble("rs0");
        check("rs0_addr", imemAddr, 32'h0000_1004);
        @(negedge clk);
        check_bubble("rs1");
        @(negedge clk);
        check_valid_instr("rs2", 32'h0000_1000);
        @(negedge clk);
        check_valid_instr("rs3", 32'h0000_1004);

        // Flush while stalled still kills decode; stall then holds the bubble.
        en    = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check_bubble("flush");
        check("flush_pcD", pcD, 32'd0);
        check("flush_instrD", instrD, NOP);
        flush = 1'b0;
        @(negedge clk);
        check_bubble("flush_hold");
        check("flush_hold_pcD", pcD, 32'd0);
        en = 1'b1;
        @(negedge clk);
        check_valid_instr("post_flush", 32'h0000_1008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
